// File: rtl/gpio_amm_master.sv
// gpio_amm_master
//   Avalon-MM initiator. Accepts one read or write command at a time on a
//   valid/ready command port and runs it as a single Avalon-MM transfer.
//   It handles waitrequest stalls and variable read latency via readdatavalid.
//   One response is returned per command. A per-phase timeout guarantees that
//   response even if the responder hangs.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake
//   cmd_write_i           1 = write, 0 = read
//   cmd_address_i         target word address
//   cmd_writedata_i       write data
//   rsp_valid_o/ready_i   response handshake
//   rsp_readdata_o        read data (0 for writes and timeouts)
//   rsp_timeout_o         transfer aborted by timeout
//   amm_*                 Avalon-MM master signals

module gpio_amm_master #(
    parameter int unsigned AMM_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_address_i,
    input  logic [AMM_WIDTH-1:0]  cmd_writedata_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [AMM_WIDTH-1:0]  rsp_readdata_o,
    output logic                  rsp_timeout_o,

    output logic [ADDR_WIDTH-1:0] amm_address_o,
    output logic                  amm_write_o,
    output logic [AMM_WIDTH-1:0]  amm_writedata_o,
    output logic                  amm_read_o,
    input  logic                  amm_waitrequest_i,
    input  logic [AMM_WIDTH-1:0]  amm_readdata_i,
    input  logic                  amm_readdatavalid_i
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdWait,
        StResp
    } state_e;

    state_e                r_state, w_state_d;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
    logic [AMM_WIDTH-1:0]  r_wdata, w_wdata_d;
    logic [AMM_WIDTH-1:0]  r_rdata, w_rdata_d;
    logic                  r_timeout, w_timeout_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d;

    logic                  w_cmd_ready;
    logic                  w_at_limit;

    assign w_cmd_ready = (r_state == StIdle) && !rst_i;
    // Last cycle of the current wait phase; absent completion here means abort.
    assign w_at_limit  = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_d   = r_state;
        w_addr_d    = r_addr;
        w_wdata_d   = r_wdata;
        w_rdata_d   = r_rdata;
        w_timeout_d = r_timeout;
        w_cnt_d     = r_cnt;

        unique case (r_state)
            StIdle: begin
                if (cmd_valid_i && w_cmd_ready) begin
                    w_addr_d    = cmd_address_i;
                    w_wdata_d   = cmd_writedata_i;
                    w_rdata_d   = '0;
                    w_timeout_d = 1'b0;
                    w_cnt_d     = '0;
                    w_state_d   = cmd_write_i ? StWr : StRd;
                end
            end
            StWr: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                // Completion is checked first so it wins over a coinciding timeout.
                if (!amm_waitrequest_i) begin
                    w_rdata_d   = '0;
                    w_timeout_d = 1'b0;
                    w_state_d   = StResp;
                end else if (w_at_limit) begin
                    w_rdata_d   = '0;
                    w_timeout_d = 1'b1;
                    w_state_d   = StResp;
                end
            end
            StRd: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (!amm_waitrequest_i) begin
                    w_cnt_d   = '0;
                    w_state_d = StRdWait;
                end else if (w_at_limit) begin
                    w_rdata_d   = '0;
                    w_timeout_d = 1'b1;
                    w_state_d   = StResp;
                end
            end
            StRdWait: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (amm_readdatavalid_i) begin
                    w_rdata_d   = amm_readdata_i;
                    w_timeout_d = 1'b0;
                    w_state_d   = StResp;
                end else if (w_at_limit) begin
                    w_rdata_d   = '0;
                    w_timeout_d = 1'b1;
                    w_state_d   = StResp;
                end
            end
            StResp: begin
                // Response fields are untouched here, so stray beats cannot alter them.
                if (rsp_ready_i) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_d;
            r_addr    <= w_addr_d;
            r_wdata   <= w_wdata_d;
            r_rdata   <= w_rdata_d;
            r_timeout <= w_timeout_d;
            r_cnt     <= w_cnt_d;
        end
    end

    assign cmd_ready_o     = w_cmd_ready;
    assign rsp_valid_o     = (r_state == StResp);
    assign rsp_readdata_o  = r_rdata;
    assign rsp_timeout_o   = r_timeout;
    assign amm_address_o   = r_addr;
    assign amm_writedata_o = r_wdata;
    assign amm_write_o     = (r_state == StWr);
    assign amm_read_o      = (r_state == StRd);

endmodule

// File: tb/tb_gpio_amm_master.sv
// tb_gpio_amm_master
//   Directed bench for gpio_amm_master with hand-computed expectations.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.

module tb_gpio_amm_master;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_write_i;
    logic [3:0] cmd_address_i;
    logic [7:0] cmd_writedata_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_readdata_o;
    logic       rsp_timeout_o;
    logic [3:0] amm_address_o;
    logic       amm_write_o;
    logic [7:0] amm_writedata_o;
    logic       amm_read_o;
    logic       amm_waitrequest_i;
    logic [7:0] amm_readdata_i;
    logic       amm_readdatavalid_i;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    gpio_amm_master #(
        .AMM_WIDTH  (8),
        .ADDR_WIDTH (4),
        .TIMEOUT    (16)
    ) u_dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .cmd_valid_i         (cmd_valid_i),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_write_i         (cmd_write_i),
        .cmd_address_i       (cmd_address_i),
        .cmd_writedata_i     (cmd_writedata_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_readdata_o      (rsp_readdata_o),
        .rsp_timeout_o       (rsp_timeout_o),
        .amm_address_o       (amm_address_o),
        .amm_write_o         (amm_write_o),
        .amm_writedata_o     (amm_writedata_o),
        .amm_read_o          (amm_read_o),
        .amm_waitrequest_i   (amm_waitrequest_i),
        .amm_readdata_i      (amm_readdata_i),
        .amm_readdatavalid_i (amm_readdatavalid_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Present a command at the falling edge; it is taken at the next rising edge.
    task automatic issue(input logic wr, input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk_i);
        check("issue_ready", 32'(cmd_ready_o), 1);
        cmd_valid_i     = 1'b1;
        cmd_write_i     = wr;
        cmd_address_i   = addr;
        cmd_writedata_i = data;
        cyc();
        cmd_valid_i = 1'b0;
    endtask

    task automatic take();
        rsp_ready_i = 1'b1;
        cyc();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_i               = 1'b1;
        cmd_valid_i         = 1'b0;
        cmd_write_i         = 1'b0;
        cmd_address_i       = '0;
        cmd_writedata_i     = '0;
        rsp_ready_i         = 1'b0;
        amm_waitrequest_i   = 1'b0;
        amm_readdata_i      = '0;
        amm_readdatavalid_i = 1'b0;

        // Reset values
        cyc();
        cyc();
        @(negedge clk_i);
        check("rst_cmd_ready", 32'(cmd_ready_o), 0);
        check("rst_read", 32'(amm_read_o), 0);
        check("rst_write", 32'(amm_write_o), 0);
        check("rst_addr", 32'(amm_address_o), 0);
        check("rst_wdata", 32'(amm_writedata_o), 0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 0);
        check("rst_rsp_to", 32'(rsp_timeout_o), 0);
        check("rst_rsp_data", 32'(rsp_readdata_o), 0);
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready", 32'(cmd_ready_o), 1);

        // Write, no stall: one write cycle, response 2 cycles after accept
        issue(1'b1, 4'h1, 8'hA5);
        @(negedge clk_i);
        check("w1_write", 32'(amm_write_o), 1);
        check("w1_read", 32'(amm_read_o), 0);
        check("w1_addr", 32'(amm_address_o), 32'h1);
        check("w1_wdata", 32'(amm_writedata_o), 32'hA5);
        check("w1_busy", 32'(cmd_ready_o), 0);
        cyc();
        @(negedge clk_i);
        check("w1_write_drop", 32'(amm_write_o), 0);
        check("w1_rsp_valid", 32'(rsp_valid_o), 1);
        check("w1_rsp_data", 32'(rsp_readdata_o), 0);
        check("w1_rsp_to", 32'(rsp_timeout_o), 0);
        take();
        @(negedge clk_i);
        check("w1_idle_valid", 32'(rsp_valid_o), 0);
        check("w1_idle_ready", 32'(cmd_ready_o), 1);
        check("w1_addr_hold", 32'(amm_address_o), 32'h1);

        // Read, 3 stall cycles, data one cycle after accept
        amm_waitrequest_i = 1'b1;
        issue(1'b0, 4'h2, 8'h00);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            amm_waitrequest_i = (i < 3);
            @(negedge clk_i);
            if (amm_read_o) n++;
            cyc();
        end
        amm_waitrequest_i   = 1'b0;
        amm_readdatavalid_i = 1'b1;
        amm_readdata_i      = 8'h3C;
        @(negedge clk_i);
        check("r1_read_drop", 32'(amm_read_o), 0);
        check("r1_read_cycles", 32'(n), 4);
        check("r1_no_rsp_yet", 32'(rsp_valid_o), 0);
        cyc();
        amm_readdatavalid_i = 1'b0;
        amm_readdata_i      = 8'h00;
        @(negedge clk_i);
        check("r1_rsp_valid", 32'(rsp_valid_o), 1);
        check("r1_rsp_data", 32'(rsp_readdata_o), 32'h3C);
        check("r1_rsp_to", 32'(rsp_timeout_o), 0);
        take();

        // Read timeout in RD_WAIT, then a late beat that must be ignored
        issue(1'b0, 4'h3, 8'h00);
        @(negedge clk_i);
        check("r2_read", 32'(amm_read_o), 1);
        cyc();
        n = 0;
        while (n < 40) begin
            @(negedge clk_i);
            if (rsp_valid_o) break;
            n++;
            cyc();
        end
        check("r2_wait_cycles", 32'(n), 16);
        check("r2_rsp_to", 32'(rsp_timeout_o), 1);
        check("r2_rsp_data", 32'(rsp_readdata_o), 0);
        cyc();
        amm_readdatavalid_i = 1'b1;
        amm_readdata_i      = 8'hFF;
        cyc();
        amm_readdatavalid_i = 1'b0;
        @(negedge clk_i);
        check("r2_late_valid", 32'(rsp_valid_o), 1);
        check("r2_late_data", 32'(rsp_readdata_o), 0);
        check("r2_late_to", 32'(rsp_timeout_o), 1);
        take();

        // Write with waitrequest stuck high
        amm_waitrequest_i = 1'b1;
        issue(1'b1, 4'h4, 8'h5A);
        n = 0;
        while (n < 40) begin
            @(negedge clk_i);
            if (!amm_write_o) break;
            n++;
            cyc();
        end
        check("w2_write_cycles", 32'(n), 16);
        check("w2_rsp_valid", 32'(rsp_valid_o), 1);
        check("w2_rsp_to", 32'(rsp_timeout_o), 1);
        check("w2_rsp_data", 32'(rsp_readdata_o), 0);
        amm_waitrequest_i = 1'b0;
        take();
        issue(1'b1, 4'h5, 8'h77);
        @(negedge clk_i);
        check("w3_write", 32'(amm_write_o), 1);
        check("w3_wdata", 32'(amm_writedata_o), 32'h77);
        cyc();
        @(negedge clk_i);
        check("w3_rsp_valid", 32'(rsp_valid_o), 1);
        check("w3_rsp_to", 32'(rsp_timeout_o), 0);
        take();

        // Response backpressure with a pending command waiting
        issue(1'b0, 4'h6, 8'h00);
        cyc();
        amm_readdatavalid_i = 1'b1;
        amm_readdata_i      = 8'hC3;
        cyc();
        amm_readdatavalid_i = 1'b0;
        amm_readdata_i      = 8'h00;
        cmd_valid_i     = 1'b1;
        cmd_write_i     = 1'b1;
        cmd_address_i   = 4'h7;
        cmd_writedata_i = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_valid", 32'(rsp_valid_o), 1);
            check("bp_data", 32'(rsp_readdata_o), 32'hC3);
            check("bp_ready", 32'(cmd_ready_o), 0);
            check("bp_write", 32'(amm_write_o), 0);
            cyc();
        end
        rsp_ready_i = 1'b1;
        cyc();
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("bp_after_ready", 32'(cmd_ready_o), 1);
        cyc();
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_new_write", 32'(amm_write_o), 1);
        check("bp_new_addr", 32'(amm_address_o), 32'h7);
        check("bp_new_wdata", 32'(amm_writedata_o), 32'h11);
        cyc();
        @(negedge clk_i);
        check("bp_new_rsp", 32'(rsp_valid_o), 1);
        take();

        // Reset in cycle 2 of a stalled read
        amm_waitrequest_i = 1'b1;
        issue(1'b0, 4'h8, 8'h00);
        @(negedge clk_i);
        check("rr_read", 32'(amm_read_o), 1);
        cyc();
        rst_i = 1'b1;
        cyc();
        @(negedge clk_i);
        check("rr_read_drop", 32'(amm_read_o), 0);
        check("rr_no_rsp", 32'(rsp_valid_o), 0);
        check("rr_ready_in_rst", 32'(cmd_ready_o), 0);
        cyc();
        rst_i = 1'b0;
        amm_waitrequest_i = 1'b0;
        @(negedge clk_i);
        check("rr_ready_after", 32'(cmd_ready_o), 1);
        check("rr_no_rsp_after", 32'(rsp_valid_o), 0);
        check("rr_addr_cleared", 32'(amm_address_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_amm_master.md
# gpio_amm_master

Avalon-MM initiator that turns single read/write commands from a local command port into Avalon-MM master transfers. It drives the memory-mapped bus toward `gpio_controller` and any other Avalon-MM responder in the design. The block handles `waitrequest` stalls and variable read latency via `readdatavalid`, and returns one response per command. A timeout counter guarantees a response even when the responder hangs.

## Interface
- `AMM_WIDTH`, 8: Avalon-MM data width; also the width of command write data and response read data.
- `ADDR_WIDTH`, 4: Avalon-MM word address width.
- `TIMEOUT`, 16: maximum number of cycles spent in any single wait phase; must be ≥ 2.

Ports:
- `clk_i`  in  1  single clock; all logic is on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  block accepts a command.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_address_i`  in  ADDR_WIDTH  target word address.
- `cmd_writedata_i`  in  AMM_WIDTH  write data.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  consumer takes the response.
- `rsp_readdata_o`  out  AMM_WIDTH  read data; 0 for writes and timeouts.
- `rsp_timeout_o`  out  1  transfer aborted by timeout.
- `amm_address_o`  out  ADDR_WIDTH  Avalon-MM address.
- `amm_write_o`  out  1  Avalon-MM write.
- `amm_writedata_o`  out  AMM_WIDTH  Avalon-MM write data.
- `amm_read_o`  out  1  Avalon-MM read.
- `amm_waitrequest_i`  in  1  responder stall.
- `amm_readdata_i`  in  AMM_WIDTH  read data.
- `amm_readdatavalid_i`  in  1  read data valid.

## Operation
- States: IDLE, WR, RD, RD_WAIT, RESP.
- IDLE:
  - `cmd_ready_o` = 1; it is combinational: (state == IDLE) && !rst_i.
  - When `cmd_valid_i && cmd_ready_o`, register the address, write data and direction.
  - Go to WR or RD.
- WR:
  - `amm_write_o` = 1; address and write data are held stable.
  - The cycle with `amm_waitrequest_i` = 0 completes the transfer → RESP with timeout = 0 and readdata = 0.
- RD:
  - `amm_read_o` = 1 and the address is held.
  - The cycle with `amm_waitrequest_i` = 0 is the accept cycle → RD_WAIT.
  - `amm_readdatavalid_i` is ignored in RD.
- RD_WAIT:
  - No bus request is driven.
  - On `amm_readdatavalid_i` = 1, capture `amm_readdata_i` → RESP.
- RESP:
  - `rsp_valid_o` = 1, with response fields held stable until `rsp_ready_i` = 1.
  - On that cycle → IDLE.
- Timeout:
  - The counter, of width $clog2(TIMEOUT+1), clears on entry to WR, RD and RD_WAIT and increments every cycle spent in the state.
  - If the completion condition is absent on the cycle the counter equals TIMEOUT-1: deassert the request, set `rsp_timeout_o` = 1 with readdata = 0, and go to RESP.
  - If completion and the timeout point coincide, completion wins and timeout = 0.
- `amm_readdatavalid_i` outside RD_WAIT is a late or spurious beat. It is ignored and never alters a pending response.
- At most one outstanding transfer; no pipelined reads.
- `amm_address_o`/`amm_writedata_o` hold their last values when idle; `amm_read_o` and `amm_write_o` are never both 1.

## Timing
- Reset (synchronous, `rst_i` = 1 at a clock edge) forces:
  - state = IDLE;
  - `amm_read_o` = `amm_write_o` = 0;
  - `amm_address_o` = 0, `amm_writedata_o` = 0;
  - `rsp_valid_o` = 0, `rsp_timeout_o` = 0, `rsp_readdata_o` = 0;
  - counter = 0;
  - `cmd_ready_o` = 0 while `rst_i` is high.
- Reset mid-transfer aborts immediately with no response. The bus request drops in the cycle after the reset edge.
- Command accepted at edge N: request asserted in cycle N+1.
- Write with no stall: `rsp_valid_o` in cycle N+2. Each stall cycle adds 1.
- Read with no stall and readdatavalid one cycle after accept: readdatavalid in cycle N+2, `rsp_valid_o` in cycle N+3.
- Back-to-back: after the RESP handshake at edge M, `cmd_ready_o` = 1 in cycle M+1. Peak throughput is one command per 3 cycles (write).
- Timeout response appears TIMEOUT cycles after entering the wait state.

## Test plan
- Write, no stall: cmd write addr 1, data 0xA5 → `amm_write_o` high for exactly 1 cycle with addr 1 and data 0xA5; response valid 2 cycles after accept, readdata 0, timeout 0.
- Read with 3 stall cycles then readdatavalid 1 cycle after accept, data 0x3C → `amm_read_o` high for 4 cycles; response readdata 0x3C, timeout 0.
- Read, responder never asserts readdatavalid, TIMEOUT = 16 → response after 16 cycles in RD_WAIT with timeout 1 and readdata 0. A late readdatavalid afterward is ignored.
- Write with `amm_waitrequest_i` stuck at 1 → `amm_write_o` drops after 16 cycles; response timeout 1. A subsequent command completes normally.
- Response backpressure: `rsp_ready_i` low for 5 cycles → `rsp_valid_o` and data stable, `cmd_ready_o` = 0 throughout. A new command is accepted only after the handshake.
- Reset asserted in cycle 2 of a stalled read → `amm_read_o` = 0 and `rsp_valid_o` = 0 the next cycle; `cmd_ready_o` = 1 the first cycle after `rst_i` deasserts.
